// File: rtl/dm_subword_mem.sv
// Data memory for the pipelined MIPS core: word/half/byte loads and stores over a
// valid/ready request channel, with a configurable load latency and error flagging for
// misaligned, out-of-range and reserved-size accesses. The memory is zeroed one word per
// cycle after reset.
// Optional feature: define DM_TRACE_EN to print a trace line for every committed store.
module dm_subword_mem #(
  parameter int unsigned DEPTH  = 3072,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_busy
);

  typedef enum logic [1:0] {StInit, StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [2:0]        cnt_q;
  logic [31:0]       load_q;
  logic              err_hold_q;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] safe_idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              misaligned;
  logic              req_err;
  logic              accept;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       load_ext;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       store_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [31:0]       mem_wdata;

  // Decode the request: index, lane, and the three error sources.
  always_comb begin
    word_idx     = req_addr[ADDR_W+1:2];
    lane         = req_addr[1:0];
    out_of_range = ((req_addr >> (ADDR_W + 2)) != 32'd0) || (32'(word_idx) >= DEPTH);
    misaligned   = ((req_size == 2'b01) && lane[0]) || ((req_size == 2'b10) && (lane != 2'b00));
    req_err      = out_of_range || misaligned || (req_size == 2'b11);
    // Keep the read index inside the array even for rejected addresses.
    safe_idx     = out_of_range ? '0 : word_idx;
    accept       = req_valid && req_ready && (state_q == StIdle);
  end

  // Read the addressed word, then extract and extend the loaded lane(s).
  always_comb begin
    rd_word  = mem[safe_idx];
    shifted  = rd_word >> {lane, 3'b000};
    load_ext = '0;
    if (!req_err) begin
      case (req_size)
        2'b00:   load_ext = req_unsigned ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
        2'b01:   load_ext = req_unsigned ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
        default: load_ext = rd_word;
      endcase
    end
  end

  // Merge right-aligned store data into the current word using per-lane enables.
  always_comb begin
    case (req_size)
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << lane;
        wd = {2{req_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = req_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      store_word[8*i +: 8] = be[i] ? wd[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // Single write port: clearing during INIT, committed stores otherwise.
  always_comb begin
    mem_we    = (state_q == StInit) || (accept && req_we && !req_err);
    mem_widx  = (state_q == StInit) ? idx_q : safe_idx;
    mem_wdata = (state_q == StInit) ? 32'd0 : store_word;
  end

  // Memory array write (no reset; contents cleared by the INIT sweep).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      idx_q      <= '0;
      cnt_q      <= '0;
      load_q     <= '0;
      err_hold_q <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      init_busy  <= 1'b1;
    end else begin
      case (state_q)
        StInit: begin
          if (32'(idx_q) == DEPTH - 1) begin
            idx_q     <= '0;
            state_q   <= StIdle;
            req_ready <= 1'b1;
            init_busy <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StIdle: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (req_we || (LAT == 1)) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_rdata <= req_we ? 32'd0 : load_ext;
              rsp_err   <= req_err;
            end else begin
              state_q    <= StWait;
              cnt_q      <= 3'(LAT - 1);
              load_q     <= load_ext;
              err_hold_q <= req_err;
            end
`ifdef DM_TRACE_EN
            if (req_we && !req_err) begin
              $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, store_word);
            end
`endif
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == 3'd1) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_q;
            rsp_err   <= err_hold_q;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state_q <= StInit;
      endcase
    end
  end

`ifndef DM_TRACE_EN
  // The PC only feeds the store trace.
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule
